// File: rtl/tv_vector_player.sv
// Test-vector player/scorer: assembles a 32-bit word stream into one wide registered
// input vector, waits for the circuit under test to settle, then scores its output bit.
module tv_vector_player #(
    parameter int VEC_W  = 1894,
    parameter int WORD_W = 32,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_last,
    output logic [VEC_W-1:0]  vec_o,
    input  logic              dut_i,
    output logic              res_valid,
    output logic              res_match,
    output logic [CNT_W-1:0]  vec_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              frame_err
);

    localparam int NWORDS = (VEC_W + WORD_W - 1) / WORD_W;
    localparam int TAIL   = VEC_W - (NWORDS - 1) * WORD_W;
    localparam int SH_W   = (NWORDS - 1) * WORD_W;
    localparam int WIDX_W = $clog2(NWORDS);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_DROP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_SCORE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [WIDX_W-1:0]   widx_r;
    logic [WIDX_W-1:0]   widx_nx_s;
    logic [3:0]          settle_r;
    logic [3:0]          settle_nx_s;
    logic [SH_W-1:0]     shadow_r;
    logic [VEC_W-1:0]    vec_r;
    logic                exp_r;
    logic                s_ready_r;
    logic                res_valid_r;
    logic                res_match_r;
    logic [CNT_W-1:0]    vec_cnt_r;
    logic [CNT_W-1:0]    err_cnt_r;
    logic                frame_err_r;

    logic                accept_s;
    logic                last_word_s;
    logic                shadow_we_s;
    logic                load_vec_s;
    logic                frame_bad_s;
    logic                score_s;
    logic                match_s;

    assign accept_s    = s_valid & s_ready_r;
    assign last_word_s = (widx_r == WIDX_W'(NWORDS - 1));
    assign match_s     = (dut_i == exp_r);

    // Next-state logic: frame assembly, malformed-frame handling and settle/score sequencing
    always_comb begin
        state_nx_s  = state_r;
        widx_nx_s   = widx_r;
        settle_nx_s = settle_r;
        shadow_we_s = 1'b0;
        load_vec_s  = 1'b0;
        frame_bad_s = 1'b0;
        score_s     = 1'b0;
        case (state_r)
            ST_LOAD: begin
                if (accept_s) begin
                    if (last_word_s) begin
                        widx_nx_s = {WIDX_W{1'b0}};
                        if (s_last) begin
                            load_vec_s  = 1'b1;
                            settle_nx_s = 4'(SETTLE - 1);
                            state_nx_s  = ST_SETTLE;
                        end else begin
                            frame_bad_s = 1'b1;
                            state_nx_s  = ST_DROP;
                        end
                    end else if (s_last) begin
                        // short frame: drop what was gathered and restart at word 0
                        frame_bad_s = 1'b1;
                        widx_nx_s   = {WIDX_W{1'b0}};
                    end else begin
                        shadow_we_s = 1'b1;
                        widx_nx_s   = widx_r + WIDX_W'(1);
                    end
                end else begin
                    widx_nx_s = widx_r;
                end
            end
            ST_DROP: begin
                if (accept_s && s_last) begin
                    state_nx_s = ST_LOAD;
                    widx_nx_s  = {WIDX_W{1'b0}};
                end else begin
                    state_nx_s = ST_DROP;
                end
            end
            ST_SETTLE: begin
                if (settle_r == 4'd0) begin
                    state_nx_s = ST_SCORE;
                end else begin
                    settle_nx_s = settle_r - 4'd1;
                end
            end
            ST_SCORE: begin
                score_s    = 1'b1;
                state_nx_s = ST_LOAD;
            end
            default: begin
                state_nx_s = ST_LOAD;
                widx_nx_s  = {WIDX_W{1'b0}};
            end
        endcase
    end

    // Control state register; ready is registered from the next state so it drops on entry to SETTLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_LOAD;
            widx_r    <= {WIDX_W{1'b0}};
            settle_r  <= 4'd0;
            s_ready_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            widx_r    <= widx_nx_s;
            settle_r  <= settle_nx_s;
            s_ready_r <= (state_nx_s == ST_LOAD) || (state_nx_s == ST_DROP);
        end
    end

    // Shadow buffer collecting the full-width words of the frame in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= {SH_W{1'b0}};
        end else begin
            for (int k = 0; k < NWORDS - 1; k++) begin
                if (shadow_we_s && (widx_r == WIDX_W'(k))) begin
                    shadow_r[k*WORD_W +: WORD_W] <= s_data;
                end
            end
        end
    end

    // Vector and expected bit are committed together, only when a well-formed frame completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_r <= {VEC_W{1'b0}};
            exp_r <= 1'b0;
        end else if (load_vec_s) begin
            vec_r <= {s_data[TAIL-1:0], shadow_r};
            exp_r <= s_data[TAIL];
        end
    end

    // Result pulse and match flag, launched from the scoring cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r <= 1'b0;
            res_match_r <= 1'b0;
        end else begin
            res_valid_r <= score_s;
            if (score_s) begin
                res_match_r <= match_s;
            end
        end
    end

    // Saturating statistics and sticky frame error; clear takes priority over any update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt_r   <= {CNT_W{1'b0}};
            err_cnt_r   <= {CNT_W{1'b0}};
            frame_err_r <= 1'b0;
        end else if (clr_i) begin
            vec_cnt_r   <= {CNT_W{1'b0}};
            err_cnt_r   <= {CNT_W{1'b0}};
            frame_err_r <= 1'b0;
        end else begin
            if (score_s && (vec_cnt_r != {CNT_W{1'b1}})) begin
                vec_cnt_r <= vec_cnt_r + CNT_W'(1);
            end
            if (score_s && !match_s && (err_cnt_r != {CNT_W{1'b1}})) begin
                err_cnt_r <= err_cnt_r + CNT_W'(1);
            end
            if (frame_bad_s) begin
                frame_err_r <= 1'b1;
            end
        end
    end

    assign s_ready   = s_ready_r;
    assign vec_o     = vec_r;
    assign res_valid = res_valid_r;
    assign res_match = res_match_r;
    assign vec_cnt   = vec_cnt_r;
    assign err_cnt   = err_cnt_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_tv_vector_player.sv
// Randomized bench for tv_vector_player: frames are built from random words, the expected
// vector is rebuilt bit-by-bit and scored against a stand-in circuit (output = vector bit 87).
module tb_tv_vector_player;

    localparam int VW  = 1894;
    localparam int WW  = 32;
    localparam int CW  = 4;
    localparam int SAT = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr_i = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic [WW-1:0] s_data = '0;
    logic          s_ready;
    logic [VW-1:0] vec_o;
    logic          dut_i;
    logic          res_valid;
    logic          res_match;
    logic [CW-1:0] vec_cnt;
    logic [CW-1:0] err_cnt;
    logic          frame_err;

    tv_vector_player #(.VEC_W(VW), .WORD_W(WW), .SETTLE(1), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clr_i(clr_i),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .vec_o(vec_o), .dut_i(dut_i),
        .res_valid(res_valid), .res_match(res_match),
        .vec_cnt(vec_cnt), .err_cnt(err_cnt), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // reference circuit under test: its output is simply input bit 87
    assign dut_i = vec_o[87];

    int            total = 0;
    int            bad = 0;
    logic [WW-1:0] frm [0:62];
    logic [VW-1:0] mvec = '0;
    logic [VW-1:0] nvec;
    logic          nexp;
    int            m_vec = 0;
    int            m_err = 0;
    logic          m_ferr = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: random expected bit, 1: force match, 2: force mismatch
    task automatic gen_frame(input int mode, input bit zero);
        for (int w = 0; w < 63; w++) frm[w] = zero ? 32'd0 : $urandom;
        for (int b = 0; b < VW; b++) nvec[b] = frm[b / WW][b % WW];
        case (mode)
            1:       nexp = nvec[87];
            2:       nexp = ~nvec[87];
            default: nexp = 1'($urandom_range(1, 0));
        endcase
        frm[59][6] = nexp;
    endtask

    task automatic send_word(input logic [WW-1:0] d, input logic l, input int gap);
        int n;
        s_valid = 1'b0;
        repeat (gap) tick();
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        while (!s_ready && n < 100) begin
            tick();
            n++;
        end
        if (!s_ready) check_val("ready_timeout", {63'd0, s_ready}, 64'd1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int nwords, input int last_idx, input int maxgap);
        for (int w = 0; w < nwords; w++)
            send_word(frm[w], (w == last_idx), (maxgap > 0) ? $urandom_range(maxgap, 0) : 0);
    endtask

    task automatic good_frame(input int mode, input bit zero, input int maxgap, input bit clr);
        gen_frame(mode, zero);
        send_frame(60, 59, maxgap);
        mvec = nvec;
        check_val("vec_o", {63'd0, vec_o === mvec}, 64'd1);
        check_val("ready_settle", {63'd0, s_ready}, 64'd0);
        if (clr) begin
            m_vec  = 0;
            m_err  = 0;
            m_ferr = 1'b0;
        end else begin
            if (m_vec < SAT) m_vec++;
            if (mvec[87] != nexp && m_err < SAT) m_err++;
        end
        tick();
        check_val("res_valid_early", {63'd0, res_valid}, 64'd0);
        clr_i = clr;
        tick();
        clr_i = 1'b0;
        check_val("res_valid", {63'd0, res_valid}, 64'd1);
        check_val("res_match", {63'd0, res_match}, {63'd0, mvec[87] == nexp});
        check_val("vec_cnt", vec_cnt, m_vec);
        check_val("err_cnt", err_cnt, m_err);
        check_val("frame_err", {63'd0, frame_err}, {63'd0, m_ferr});
        check_val("ready_after", {63'd0, s_ready}, 64'd1);
        tick();
        check_val("res_pulse", {63'd0, res_valid}, 64'd0);
    endtask

    task automatic bad_frame(input int nwords, input int last_idx);
        gen_frame(0, 1'b0);
        send_frame(nwords, last_idx, 0);
        m_ferr = 1'b1;
        tick();
        check_val("bad_ferr", {63'd0, frame_err}, 64'd1);
        check_val("bad_vec_hold", {63'd0, vec_o === mvec}, 64'd1);
        check_val("bad_vec_cnt", vec_cnt, m_vec);
        check_val("bad_res_valid", {63'd0, res_valid}, 64'd0);
    endtask

    task automatic reset_checks(input string tag);
        check_val({tag, "_vec"}, {63'd0, vec_o === '0}, 64'd1);
        check_val({tag, "_vcnt"}, vec_cnt, 64'd0);
        check_val({tag, "_ecnt"}, err_cnt, 64'd0);
        check_val({tag, "_ferr"}, {63'd0, frame_err}, 64'd0);
        check_val({tag, "_rv"}, {63'd0, res_valid}, 64'd0);
        check_val({tag, "_rdy"}, {63'd0, s_ready}, 64'd0);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        check_val("rdy_first", {63'd0, s_ready}, 64'd0);
        tick();
        check_val("rdy_second", {63'd0, s_ready}, 64'd1);
    endtask

    initial begin
        repeat (3) tick();
        reset_checks("reset");
        release_reset();

        good_frame(1, 1'b1, 0, 1'b0);                 // all-zero vector, exp=0
        good_frame(2, 1'b1, 0, 1'b0);                 // same vector, exp=1
        good_frame(2, 1'b1, 3, 1'b0);                 // with random valid gaps
        repeat (6) good_frame(0, 1'b0, 2, 1'b0);

        bad_frame(11, 10);                            // short frame
        good_frame(0, 1'b0, 0, 1'b0);
        bad_frame(63, 62);                            // long frame
        good_frame(0, 1'b0, 1, 1'b0);

        good_frame(0, 1'b0, 0, 1'b1);                 // clear coincident with score

        repeat (20) good_frame(2, 1'b0, 0, 1'b0);     // saturation
        check_val("err_sat", err_cnt, 64'd15);
        check_val("vec_sat", vec_cnt, 64'd15);
        good_frame(2, 1'b0, 0, 1'b1);

        gen_frame(0, 1'b0);                           // reset in mid-frame
        send_frame(30, 99, 0);
        rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        tick();
        mvec   = '0;
        m_vec  = 0;
        m_err  = 0;
        m_ferr = 1'b0;
        release_reset();
        good_frame(1, 1'b0, 0, 1'b0);
        good_frame(2, 1'b0, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
